bitstream_frame_controller: RTL

Parametrised frame engine that wraps a stochastic bitstream network. It accepts one vector of N_IN binary operands through a valid/ready handshake and drives one stochastic bit per operand per cycle for a frame of 2^LEN_LOG2 cycles. It counts the ones on N_OUT network output streams, allowing for the network's pipeline latency, and returns the counts through a valid/ready handshake. It replaces the fixed two-input, 256-cycle, testbench-driven compute sequencing with a synthesisable, multi-channel controller.

---
 rtl/bitstream_frame_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bitstream_frame_controller.sv
// Frame engine around a stochastic bitstream network: latches an operand vector,
// streams SNG bits for 2^LEN_LOG2 cycles, counts the network's ones and hands back the counts.
module bitstream_frame_controller #(
  parameter int          WIDTH    = 8,
  parameter int          N_IN     = 2,
  parameter int          N_OUT    = 1,
  parameter int          LEN_LOG2 = 8,
  parameter int          NET_LAT  = 1,
  parameter logic [15:0] SEED     = 16'b0000000010001101
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            abort,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*(WIDTH+1)-1:0]       in_data,
  output logic                            compute,
  output logic [N_IN-1:0]                 sc_out,
  input  logic [N_OUT-1:0]                sc_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_OUT*(LEN_LOG2+1)-1:0]   out_count,
  output logic [1:0]                      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; abort on that edge overrides any transfer.

  localparam int CW  = WIDTH + 1;
  localparam int KW  = LEN_LOG2 + 1;
  localparam int FCW = (LEN_LOG2 > 3) ? LEN_LOG2 : 3;
  localparam logic [FCW-1:0]   FRAME_LAST = FCW'((1 << LEN_LOG2) - 1);
  localparam logic [FCW-1:0]   FLUSH_LAST = FCW'((NET_LAT > 0) ? NET_LAT - 1 : 0);
  localparam logic [KW-1:0]    FULL       = {1'b1, {LEN_LOG2{1'b0}}};
  localparam logic [WIDTH-1:0] SEED_W     = SEED[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0] TAPS = tap_mask(WIDTH);

  // The extra term splices the all-zero state in after 100..0, giving period 2^WIDTH.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] r);
    logic fb;
    fb = (^(r & TAPS[WIDTH-1:0])) ^ (r[WIDTH-2:0] == '0);
    return {r[WIDTH-2:0], fb};
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] r, input int k);
    int s;
    s = k % WIDTH;
    return (r << s) | (r >> (WIDTH - s));
  endfunction

  state_t                  state;
  logic [WIDTH-1:0]        lfsr;
  logic [N_IN*CW-1:0]      ops;
  logic [FCW-1:0]          frame_cnt;
  logic [NET_LAT:0]        run_sr;
  logic [WIDTH-1:0]        cmp_r;
  logic [N_IN*CW-1:0]      cmp_ops;
  logic [N_IN-1:0]         sc_next;
  logic                    run_next;
  logic                    window;

  assign dbg_state = state;
  assign compute   = run_sr[0];
  assign window    = run_sr[NET_LAT];

  // The comparator looks ahead at in_data/SEED while idle so sc_out lines up with compute.
  always_comb begin
    cmp_r    = (state == IDLE) ? SEED_W : lfsr;
    cmp_ops  = (state == IDLE) ? in_data : ops;
    run_next = ((state == IDLE) && in_valid) || ((state == RUN) && (frame_cnt != FRAME_LAST));
    sc_next  = '0;
    for (int k = 0; k < N_IN; k++)
      sc_next[k] = cmp_ops[k*CW +: CW] > {1'b0, rotl(cmp_r, k)};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      sc_out    <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      lfsr      <= SEED_W;
      ops       <= '0;
      frame_cnt <= '0;
      run_sr    <= '0;
    end else if (abort) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      sc_out    <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      frame_cnt <= '0;
      run_sr    <= '0;
    end else begin
      for (int i = NET_LAT; i > 0; i--)
        run_sr[i] <= run_sr[i-1];
      run_sr[0] <= run_next;
      for (int m = 0; m < N_OUT; m++)
        if (window && sc_in[m] && (out_count[m*KW +: KW] != FULL))
          out_count[m*KW +: KW] <= out_count[m*KW +: KW] + KW'(1);
      case (state)
        IDLE: if (in_valid) begin
          ops       <= in_data;
          lfsr      <= lfsr_next(cmp_r);
          sc_out    <= sc_next;
          frame_cnt <= '0;
          out_count <= '0;
          in_ready  <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          lfsr <= lfsr_next(cmp_r);
          if (frame_cnt == FRAME_LAST) begin
            sc_out    <= '0;
            frame_cnt <= '0;
            if (NET_LAT == 0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end else begin
            sc_out    <= sc_next;
            frame_cnt <= frame_cnt + FCW'(1);
          end
        end
        FLUSH: begin
          if (frame_cnt == FLUSH_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + FCW'(1);
          end
        end
        default: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
